// File: rtl/rle_pkg.sv
// Shared token and state definitions for the zero-run encoder path.
// The downstream packer and decoder model import these as well.
package rle_pkg;

   localparam logic TOK_LIT = 1'b0;
   localparam logic TOK_RUN = 1'b1;

   // Token layout: type bit sits directly above the DATA_W-wide payload.
   localparam int TOK_PAYLOAD_LSB = 0;

   typedef enum logic {
      S_COUNT = 1'b0,
      S_PEND  = 1'b1
   } rle_state_e;

endpackage

// File: rtl/rle_out_slot.sv
// One-entry registered output slot with valid/ready handshake.
// Contents are held while out_valid && !out_ready; load wins over pop.
module rle_out_slot #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         load_last,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         out_last
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_last  <= load_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/zero_run_encoder.sv
// Collapses zero runs in the thresholded coefficient stream into RUN tokens
// and passes nonzero coefficients through as LIT tokens.
module zero_run_encoder
   import rle_pkg::*;
#(
   parameter int DATA_W = 9,
   parameter int RUN_W  = 9
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W:0]          out_data,
   output logic                     out_last
);

   localparam logic [RUN_W-1:0] MAX_RUN = '1;

   rle_state_e        state, state_nxt;
   logic [RUN_W-1:0]  run, run_nxt, run_inc;
   logic [DATA_W-1:0] pend_data;
   logic              pend_last;
   logic              live;
   logic              slot_free, accept, is_zero, set_pend;
   logic              load, load_last;
   logic [DATA_W:0]   load_data;

   assign slot_free = !out_valid || out_ready;
   // live keeps in_ready low while reset is asserted and for the cycle it releases
   assign in_ready  = live && (state == S_COUNT) && slot_free;
   assign accept    = in_valid && in_ready;
   assign is_zero   = (in_data == '0);
   assign run_inc   = run + 1'b1;

   always_comb begin
      load      = 1'b0;
      load_data = '0;
      load_last = 1'b0;
      run_nxt   = run;
      state_nxt = state;
      set_pend  = 1'b0;
      if (state == S_PEND) begin
         if (out_valid && out_ready) begin
            load      = 1'b1;
            load_data = {TOK_LIT, pend_data};
            load_last = pend_last;
            state_nxt = S_COUNT;
         end
      end else if (accept) begin
         if (is_zero) begin
            if (in_last) begin
               load      = 1'b1;
               load_data = {TOK_RUN, DATA_W'(run_inc)};
               load_last = 1'b1;
               run_nxt   = '0;
            end else if (run_inc == MAX_RUN) begin
               load      = 1'b1;
               load_data = {TOK_RUN, DATA_W'(MAX_RUN)};
               run_nxt   = '0;
            end else begin
               run_nxt   = run_inc;
            end
         end else if (run == '0) begin
            load      = 1'b1;
            load_data = {TOK_LIT, in_data};
            load_last = in_last;
         end else begin
            // Flush the open run first; the literal waits one pop in S_PEND.
            load      = 1'b1;
            load_data = {TOK_RUN, DATA_W'(run)};
            run_nxt   = '0;
            set_pend  = 1'b1;
            state_nxt = S_PEND;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_COUNT;
         run       <= '0;
         pend_data <= '0;
         pend_last <= 1'b0;
         live      <= 1'b0;
      end else begin
         live  <= 1'b1;
         state <= state_nxt;
         run   <= run_nxt;
         if (set_pend) begin
            pend_data <= in_data;
            pend_last <= in_last;
         end
      end
   end

   rle_out_slot #(.W(DATA_W + 1)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (load_data),
      .load_last (load_last),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last)
   );

endmodule

// File: tb/tb_zero_run_encoder.sv
// Directed bench for zero_run_encoder: tokens collected on output handshakes
// and compared against hand-computed expected streams.
module tb_zero_run_encoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic [8:0] in_data = '0;
   logic       out_ready = 1'b1;
   logic       in_ready, out_valid, out_last;
   logic [9:0] out_data;

   int tests = 0;
   int fails = 0;
   int stalls = 0;
   int cyc = 0;
   logic [10:0] got_q[$];
   logic [10:0] exp_q[$];

   zero_run_encoder #(.DATA_W(9), .RUN_W(9)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && out_valid && out_ready) got_q.push_back({out_last, out_data});
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [10:0] lit(input logic [8:0] d, input logic l);
      return {l, 1'b0, d};
   endfunction

   function automatic logic [10:0] runt(input int n, input logic l);
      logic [8:0] p;
      p = n[8:0];
      return {l, 1'b1, p};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [8:0] d, input logic l);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      if (!in_ready) stalls++;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("push_timeout", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic drain();
      int n = 0;
      while (out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (out_valid) check("drain_timeout", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
   endtask

   task automatic expect_tokens(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_tok%0d", tag, i), {21'd0, got_q[i]}, {21'd0, exp_q[i]});
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int c0;

      // reset state
      #2;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {22'd0, out_data}, 32'd0);
      check("rst_out_last", {31'd0, out_last}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // reset mid-run discards the pending run
      push(9'd0, 1'b0);
      push(9'd0, 1'b0);
      push(9'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      got_q.delete();
      push(9'd5, 1'b1);
      drain();
      exp_q.push_back(lit(9'd5, 1'b1));
      expect_tokens("midrst");

      // mixed block
      push(9'd7, 1'b0);
      push(9'd0, 1'b0);
      push(9'd0, 1'b0);
      push(9'd0, 1'b0);
      push(9'h1FD, 1'b0);
      check("mixed_pend_ready", {31'd0, in_ready}, 32'd0);
      push(9'd0, 1'b1);
      drain();
      exp_q.push_back(lit(9'd7, 1'b0));
      exp_q.push_back(runt(3, 1'b0));
      exp_q.push_back(lit(9'h1FD, 1'b0));
      exp_q.push_back(runt(1, 1'b1));
      expect_tokens("mixed");

      // saturation at MAX_RUN = 511
      for (int i = 0; i < 1023; i++) push(9'd0, 1'b0);
      push(9'd4, 1'b1);
      drain();
      exp_q.push_back(runt(511, 1'b0));
      exp_q.push_back(runt(511, 1'b0));
      exp_q.push_back(runt(1, 1'b0));
      exp_q.push_back(lit(9'd4, 1'b1));
      expect_tokens("sat");

      // zero-ended block followed by the next block
      push(9'd0, 1'b0);
      push(9'd0, 1'b1);
      push(9'd0, 1'b0);
      push(9'd2, 1'b1);
      drain();
      exp_q.push_back(runt(2, 1'b1));
      exp_q.push_back(runt(1, 1'b0));
      exp_q.push_back(lit(9'd2, 1'b1));
      expect_tokens("blk2");

      // idle cycles neither advance nor flush the run
      push(9'd0, 1'b0);
      repeat (3) @(negedge clk);
      push(9'd0, 1'b1);
      drain();
      exp_q.push_back(runt(2, 1'b1));
      expect_tokens("idle");

      // backpressure holds the RUN token and blocks input
      out_ready = 1'b0;
      push(9'd0, 1'b0);
      push(9'd9, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_hold%0d", i), {21'd0, out_valid, out_last, out_data}, {21'd0, 1'b1, runt(1, 1'b0)});
         check($sformatf("bp_ready%0d", i), {31'd0, in_ready}, 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      drain();
      exp_q.push_back(runt(1, 1'b0));
      exp_q.push_back(lit(9'd9, 1'b1));
      expect_tokens("bp");

      // full throughput on a nonzero stream
      stalls = 0;
      c0 = cyc;
      for (int i = 1; i <= 64; i++) push(9'(i), i == 64);
      check("thru_cycles", cyc - c0, 32'd64);
      check("thru_stalls", stalls, 32'd0);
      drain();
      for (int i = 1; i <= 64; i++) exp_q.push_back(lit(9'(i), i == 64));
      expect_tokens("thru");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
